// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem read per cycle under a
// credit limit, and buffers {pc,instr} in a small FIFO that feeds decode over valid/ready.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  output logic                   imem_req,
  output logic [15:0]            imem_addr,
  input  logic [15:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [15:0]            redirect_pc,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [15:0]            id_instr,
  output logic [15:0]            id_pc,
  output logic [15:0]            id_npc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   mem_pc_q [DEPTH];
  logic [15:0]   mem_pc_d [DEPTH];
  logic [15:0]   mem_instr_q [DEPTH];
  logic [15:0]   mem_instr_d [DEPTH];

  logic [CW:0]   credit;
  logic          push, pop;

  // Credit counts the in-flight word but not a same-cycle pop, so a returning word always fits.
  assign credit   = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign imem_req = !Rst && !redirect && (credit < (CW+1)'(DEPTH));
  assign push     = inflight_q && !redirect;
  assign pop      = (count_q != '0) && id_ready && !redirect;

  assign imem_addr = Rst ? RESET_PC : fetch_pc_q;
  assign id_valid  = !Rst && (count_q != '0);
  assign id_instr  = Rst ? 16'h0000 : mem_instr_q[rd_ptr_q];
  assign id_pc     = Rst ? 16'h0000 : mem_pc_q[rd_ptr_q];
  assign id_npc    = id_pc + 16'd1;
  assign q_count   = Rst ? '0 : count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_pc_d      = mem_pc_q;
    mem_instr_d   = mem_instr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + 16'd1;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        mem_pc_d[wr_ptr_q]    = inflight_pc_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      mem_pc_q      <= '{default: '0};
      mem_instr_q   <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mem_pc_q      <= mem_pc_d;
      mem_instr_q   <= mem_instr_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed phases push expected PCs into a scoreboard that a
// negedge monitor drains on every accepted handshake; point checks cover latency and reset.
module tb_fetch_prefetch_queue;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr, id_pc, id_npc;
  logic [2:0]  q_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb [$];

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clk(Clk), .Rst(Rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_npc(id_npc), .q_count(q_count)
  );

  always #5 Clk = ~Clk;

  // Synchronous instruction memory: mem[a] = a ^ A5A5, one-cycle read latency.
  always @(posedge Clk) if (imem_req) imem_rdata <= imem_addr ^ 16'hA5A5;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] first, input int n);
    logic [15:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      sb.push_back(p);
      p = p + 16'd1;
    end
  endtask

  task automatic chk_drained(input string name);
    chk(name, 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  always @(negedge Clk) begin
    logic [15:0] e;
    if (!Rst && !redirect && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got pc %h with empty scoreboard at %0t", id_pc, $time);
      end else begin
        e = sb.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, e ^ 16'hA5A5);
        chk("id_npc", id_npc, e + 16'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (n_cmp %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b0;
    nxt(); nxt();
    @(negedge Clk);
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(id_valid), 16'd0);
    chk("rst_count", 16'(q_count), 16'd0);
    chk("rst_pc", id_pc, 16'h0000);
    chk("rst_instr", id_instr, 16'h0000);
    nxt();

    // Streaming from reset: pcs 0..5 accepted in cycles 2..7.
    push_range(16'h0000, 6);
    Rst = 1'b0; id_ready = 1'b1;
    @(negedge Clk);
    chk("c0_req", 16'(imem_req), 16'd1);
    chk("c0_addr", imem_addr, 16'h0000);
    chk("c0_valid", 16'(id_valid), 16'd0);
    nxt();
    @(negedge Clk);
    chk("c1_valid", 16'(id_valid), 16'd0);
    nxt();
    @(negedge Clk);
    chk("c2_valid", 16'(id_valid), 16'd1);
    nxt();
    repeat (5) nxt();
    id_ready = 1'b0;
    chk_drained("stream_drained");

    // Stall from reset: FIFO fills, request stops at fetch_pc 4, then 0..7 drain gap-free.
    Rst = 1'b1;
    nxt();
    Rst = 1'b0;
    push_range(16'h0000, 8);
    repeat (6) nxt();
    @(negedge Clk);
    chk("stall_count", 16'(q_count), 16'd4);
    chk("stall_req", 16'(imem_req), 16'd0);
    chk("stall_addr", imem_addr, 16'h0004);
    nxt();
    id_ready = 1'b1;
    repeat (8) nxt();
    id_ready = 1'b0;
    chk_drained("stall_drained");

    // Redirect while full.
    repeat (4) nxt();
    @(negedge Clk);
    chk("full_count", 16'(q_count), 16'd4);
    nxt();
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge Clk);
    chk("redir_req", 16'(imem_req), 16'd0);
    nxt();
    redirect = 1'b0; id_ready = 1'b1;
    push_range(16'h0040, 4);
    @(negedge Clk);
    chk("redir_count", 16'(q_count), 16'd0);
    chk("redir_req1", 16'(imem_req), 16'd1);
    chk("redir_addr", imem_addr, 16'h0040);
    nxt();
    @(negedge Clk);
    chk("redir_valid2", 16'(id_valid), 16'd0);
    nxt();
    @(negedge Clk);
    chk("redir_valid3", 16'(id_valid), 16'd1);
    nxt();
    repeat (3) nxt();
    id_ready = 1'b0;
    chk_drained("redir_drained");

    // Back-to-back redirects: only 0x0020 takes effect.
    redirect = 1'b1; redirect_pc = 16'h0010;
    nxt();
    redirect_pc = 16'h0020;
    nxt();
    redirect = 1'b0; id_ready = 1'b1;
    push_range(16'h0020, 4);
    @(negedge Clk);
    chk("b2b_addr", imem_addr, 16'h0020);
    nxt();
    repeat (5) nxt();
    id_ready = 1'b0;
    chk_drained("b2b_drained");

    // Address wrap FFFE -> 0001.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    nxt();
    redirect = 1'b0; id_ready = 1'b1;
    push_range(16'hFFFE, 4);
    repeat (6) nxt();
    id_ready = 1'b0;
    chk_drained("wrap_drained");

    // Reset pulse during full-rate streaming.
    redirect = 1'b1; redirect_pc = 16'h0100;
    nxt();
    redirect = 1'b0; id_ready = 1'b1;
    push_range(16'h0100, 3);
    push_range(16'h0000, 4);
    repeat (5) nxt();
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_req", 16'(imem_req), 16'd0);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    chk("mid_rst_valid", 16'(id_valid), 16'd0);
    chk("mid_rst_count", 16'(q_count), 16'd0);
    chk("mid_rst_pc", id_pc, 16'h0000);
    nxt();
    Rst = 1'b0;
    @(negedge Clk);
    chk("post_rst_v0", 16'(id_valid), 16'd0);
    nxt();
    @(negedge Clk);
    chk("post_rst_v1", 16'(id_valid), 16'd0);
    nxt();
    repeat (4) nxt();
    id_ready = 1'b0;
    chk_drained("rst_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
